// File: rtl/fetch_queue_ctrl.sv
// Fetch sequencer: issues word-aligned requests under a credit limit and queues returned words for align.
// Latency: response -> o_data one cycle (zero when FETCH_QUEUE_BYPASS_EN is defined and the queue is empty).
// Backpressure: i_stall holds the head entry; requests stop once outstanding + buffered reaches DEPTH.
module fetch_queue_ctrl #(
    parameter int              DEPTH    = 4,
    parameter logic [31:0]     RESET_PC = 32'h8000_0000,
    parameter int              EXCEPT_W = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic [31:0]         i_redirect_pc,
    input  logic                i_halt,
    output logic                o_req_valid,
    output logic [31:0]         o_req_pc,
    input  logic                i_req_ready,
    input  logic                i_resp_valid,
    input  logic [31:0]         i_resp_data,
    input  logic [EXCEPT_W-1:0] i_resp_except,
    input  logic                i_stall,
    output logic                o_data_valid,
    output logic [31:0]         o_data_pc,
    output logic [15:0]         o_data_data0,
    output logic [15:0]         o_data_data1,
    output logic [EXCEPT_W-1:0] o_data_except
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_HALT = 2'd2} state_t;
    state_t state, state_nxt;

    logic [31:0]         fetch_pc, resp_pc;
    logic [CW-1:0]       outstanding, outstanding_nxt, count, drop_cnt;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [31:0]         pc_mem  [DEPTH];
    logic [31:0]         dat_mem [DEPTH];
    logic [EXCEPT_W-1:0] exc_mem [DEPTH];

    logic credit_ok, req_fire, resp_ok, resp_keep, fifo_empty;
    logic bypass_vld, bypass_take, push, pop;

    assign credit_ok  = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_C;
    assign req_fire   = o_req_valid & i_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_ok    = i_resp_valid & (outstanding != '0);
    assign resp_keep  = resp_ok & (drop_cnt == '0) & ~i_flush;
    assign fifo_empty = (count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_vld = resp_keep & fifo_empty;
`else
    assign bypass_vld = 1'b0;
`endif
    assign bypass_take = bypass_vld & ~i_stall;
    assign push        = resp_keep & ~bypass_take;
    assign pop         = ~fifo_empty & ~i_stall & ~i_flush;

    assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(resp_ok);
    assign o_req_pc        = fetch_pc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: if (i_halt)  state_nxt = S_HALT;
            S_HALT:  if (!i_halt) state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_valid = (state == S_FETCH) & ~i_flush & credit_ok;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (i_flush) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= i_redirect_pc;
                resp_pc  <= i_redirect_pc;
                drop_cnt <= outstanding_nxt;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (req_fire)  fetch_pc <= fetch_pc + 32'd4;
                if (resp_keep) resp_pc  <= resp_pc + 32'd4;
                if (resp_ok && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= resp_pc;
            dat_mem[wr_ptr] <= i_resp_data;
            exc_mem[wr_ptr] <= i_resp_except;
        end
    end

    always_comb begin
        o_data_valid  = 1'b0;
        o_data_pc     = '0;
        o_data_data0  = '0;
        o_data_data1  = '0;
        o_data_except = '0;
        if (!fifo_empty) begin
            o_data_valid  = 1'b1;
            o_data_pc     = pc_mem[rd_ptr];
            o_data_data0  = dat_mem[rd_ptr][15:0];
            o_data_data1  = dat_mem[rd_ptr][31:16];
            o_data_except = exc_mem[rd_ptr];
        end else if (bypass_vld) begin
            o_data_valid  = 1'b1;
            o_data_pc     = resp_pc;
            o_data_data0  = i_resp_data[15:0];
            o_data_data1  = i_resp_data[31:16];
            o_data_except = i_resp_except;
        end
    end
endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Directed bench for fetch_queue_ctrl (default build, DEPTH=4): cycle table plus corner-case sequences.
// Inputs change on the falling edge; outputs are compared 1 time unit later.
module tb_fetch_queue_ctrl;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_flush;
    logic [31:0] i_redirect_pc;
    logic        i_halt;
    logic        o_req_valid;
    logic [31:0] o_req_pc;
    logic        i_req_ready;
    logic        i_resp_valid;
    logic [31:0] i_resp_data;
    logic [3:0]  i_resp_except;
    logic        i_stall;
    logic        o_data_valid;
    logic [31:0] o_data_pc;
    logic [15:0] o_data_data0;
    logic [15:0] o_data_data1;
    logic [3:0]  o_data_except;

    fetch_queue_ctrl #(.DEPTH(4), .RESET_PC(32'h8000_0000), .EXCEPT_W(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_redirect_pc(i_redirect_pc),
        .i_halt(i_halt), .o_req_valid(o_req_valid), .o_req_pc(o_req_pc),
        .i_req_ready(i_req_ready), .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
        .i_resp_except(i_resp_except), .i_stall(i_stall), .o_data_valid(o_data_valid),
        .o_data_pc(o_data_pc), .o_data_data0(o_data_data0), .o_data_data1(o_data_data1),
        .o_data_except(o_data_except)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        fl;
        logic [31:0] rdpc;
        logic        hl;
        logic        rdy;
        logic        rv;
        logic [31:0] rdat;
        logic [3:0]  rex;
        logic        st;
        logic        e_rqv;
        logic [31:0] e_rqpc;
        logic        e_dv;
        logic [31:0] e_dpc;
        logic [15:0] e_d0;
        logic [15:0] e_d1;
        logic [3:0]  e_ex;
    } row_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_row = 0;

    function automatic logic [31:0] word(input int k);
        return {16'hA000 + 16'(k), 16'hB000 + 16'(k)};
    endfunction

    function automatic row_t mk(input logic fl, input logic [31:0] rdpc, input logic hl,
                                input logic rdy, input logic rv, input int k, input logic [3:0] ex,
                                input logic st, input logic e_rqv, input logic [31:0] e_rqpc,
                                input logic e_dv, input logic [31:0] e_dpc, input int e_k,
                                input logic [3:0] e_ex);
        row_t r;
        logic [31:0] ew;
        ew       = word(e_k);
        r.fl     = fl;   r.rdpc = rdpc; r.hl = hl; r.rdy = rdy; r.rv = rv;
        r.rdat   = rv ? word(k) : 32'h0;
        r.rex    = ex;   r.st = st;
        r.e_rqv  = e_rqv; r.e_rqpc = e_rqpc; r.e_dv = e_dv;
        r.e_dpc  = e_dv ? e_dpc : 32'h0;
        r.e_d0   = e_dv ? ew[15:0]  : 16'h0;
        r.e_d1   = e_dv ? ew[31:16] : 16'h0;
        r.e_ex   = e_dv ? e_ex : 4'h0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", nm, cur_row, act, exp);
        end
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic apply(input row_t r);
        i_flush = r.fl; i_redirect_pc = r.rdpc; i_halt = r.hl; i_req_ready = r.rdy;
        i_resp_valid = r.rv; i_resp_data = r.rdat; i_resp_except = r.rex; i_stall = r.st;
        #1;
        chk("req_valid",   32'(o_req_valid),   32'(r.e_rqv));
        chk("req_pc",      o_req_pc,           r.e_rqpc);
        chk("data_valid",  32'(o_data_valid),  32'(r.e_dv));
        chk("data_pc",     o_data_pc,          r.e_dpc);
        chk("data0",       32'(o_data_data0),  32'(r.e_d0));
        chk("data1",       32'(o_data_data1),  32'(r.e_d1));
        chk("data_except", 32'(o_data_except), 32'(r.e_ex));
        @(posedge i_clk);
        @(negedge i_clk);
        cur_row++;
    endtask

    row_t vec[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_flush = 0; i_redirect_pc = 0; i_halt = 0; i_req_ready = 0;
        i_resp_valid = 0; i_resp_data = 0; i_resp_except = 0; i_stall = 0;

        // Streaming with 1-cycle memory, then a 10-cycle stall that saturates credits.
        vec.push_back(mk(0,0,0,1,0,0,0,0, 0,32'h8000_0000, 0,0,0,0));
        vec.push_back(mk(0,0,0,1,0,0,0,0, 1,32'h8000_0000, 0,0,0,0));
        vec.push_back(mk(0,0,0,1,1,1,0,0, 1,32'h8000_0004, 0,0,0,0));
        vec.push_back(mk(0,0,0,1,1,2,0,0, 1,32'h8000_0008, 1,32'h8000_0000,1,0));
        vec.push_back(mk(0,0,0,1,1,3,0,0, 1,32'h8000_000C, 1,32'h8000_0004,2,0));
        vec.push_back(mk(0,0,0,1,1,4,0,1, 1,32'h8000_0010, 1,32'h8000_0008,3,0));
        vec.push_back(mk(0,0,0,1,1,5,0,1, 1,32'h8000_0014, 1,32'h8000_0008,3,0));
        vec.push_back(mk(0,0,0,1,1,6,0,1, 0,32'h8000_0018, 1,32'h8000_0008,3,0));
        for (int i = 0; i < 7; i++)
            vec.push_back(mk(0,0,0,1,0,0,0,1, 0,32'h8000_0018, 1,32'h8000_0008,3,0));
        vec.push_back(mk(0,0,0,1,0,0,0,0, 0,32'h8000_0018, 1,32'h8000_0008,3,0));
        vec.push_back(mk(0,0,0,1,0,0,0,0, 1,32'h8000_0018, 1,32'h8000_000C,4,0));
        vec.push_back(mk(0,0,0,1,1,7,0,0, 1,32'h8000_001C, 1,32'h8000_0010,5,0));
        vec.push_back(mk(0,0,0,0,1,8,0,0, 1,32'h8000_0020, 1,32'h8000_0014,6,0));
        vec.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h8000_0020, 1,32'h8000_0018,7,0));
        vec.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h8000_0020, 1,32'h8000_001C,8,0));
        vec.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h8000_0020, 0,0,0,0));

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_req_valid",  32'(o_req_valid),  32'h0);
        chk("rst_req_pc",     o_req_pc,          32'h8000_0000);
        chk("rst_data_valid", 32'(o_data_valid), 32'h0);
        chk("rst_data_pc",    o_data_pc,         32'h0);
        chk("rst_data",       {o_data_data1, o_data_data0}, 32'h0);
        i_rst = 1'b0;

        foreach (vec[i]) apply(vec[i]);

        // Flush with 3 requests in flight: three responses discarded, restart at 0x1000.
        apply(mk(0,0,0,1,0,0,0,0, 1,32'h8000_0020, 0,0,0,0));
        apply(mk(0,0,0,1,0,0,0,0, 1,32'h8000_0024, 0,0,0,0));
        apply(mk(0,0,0,1,0,0,0,0, 1,32'h8000_0028, 0,0,0,0));
        apply(mk(1,32'h1000,0,1,0,0,0,0, 0,32'h8000_002C, 0,0,0,0));
        apply(mk(0,0,0,1,1,20,0,0, 1,32'h0000_1000, 0,0,0,0));
        apply(mk(0,0,0,0,1,21,0,0, 1,32'h0000_1004, 0,0,0,0));
        apply(mk(0,0,0,0,1,22,0,0, 1,32'h0000_1004, 0,0,0,0));
        apply(mk(0,0,0,0,1,9,0,0,  1,32'h0000_1004, 0,0,0,0));
        apply(mk(0,0,0,0,0,0,0,0,  1,32'h0000_1004, 1,32'h0000_1000,9,0));

        // Flush coincident with a response, 2 outstanding: exactly one more drop; stray response ignored.
        apply(mk(0,0,0,1,0,0,0,0, 1,32'h0000_1004, 0,0,0,0));
        apply(mk(0,0,0,1,0,0,0,0, 1,32'h0000_1008, 0,0,0,0));
        apply(mk(1,32'h2000,0,1,1,23,0,0, 0,32'h0000_100C, 0,0,0,0));
        apply(mk(0,0,0,1,1,24,0,0, 1,32'h0000_2000, 0,0,0,0));
        apply(mk(0,0,0,0,1,10,0,0, 1,32'h0000_2004, 0,0,0,0));
        apply(mk(0,0,0,0,0,0,0,0,  1,32'h0000_2004, 1,32'h0000_2000,10,0));
        apply(mk(0,0,0,0,1,11,0,0, 1,32'h0000_2004, 0,0,0,0));
        apply(mk(0,0,0,0,0,0,0,0,  1,32'h0000_2004, 0,0,0,0));

        // Halt mid-stream with an excepting word; queue drains, fetch resumes sequentially.
        apply(mk(0,0,0,1,0,0,0,0,    1,32'h0000_2004, 0,0,0,0));
        apply(mk(0,0,1,1,1,12,4'h1,0, 1,32'h0000_2008, 0,0,0,0));
        apply(mk(0,0,1,1,1,13,0,0,   0,32'h0000_200C, 1,32'h0000_2004,12,4'h1));
        apply(mk(0,0,1,1,0,0,0,0,    0,32'h0000_200C, 1,32'h0000_2008,13,0));
        apply(mk(0,0,1,1,0,0,0,0,    0,32'h0000_200C, 0,0,0,0));
        apply(mk(0,0,0,1,0,0,0,0,    0,32'h0000_200C, 0,0,0,0));
        apply(mk(0,0,0,0,0,0,0,0,    1,32'h0000_200C, 0,0,0,0));

        // Flush during halt to the top of the address space; PCs wrap to zero.
        apply(mk(0,0,1,0,0,0,0,0,             1,32'h0000_200C, 0,0,0,0));
        apply(mk(1,32'hFFFF_FFFC,1,1,0,0,0,0, 0,32'h0000_200C, 0,0,0,0));
        apply(mk(0,0,1,1,0,0,0,0,             0,32'hFFFF_FFFC, 0,0,0,0));
        apply(mk(0,0,0,1,0,0,0,0,             0,32'hFFFF_FFFC, 0,0,0,0));
        apply(mk(0,0,0,1,0,0,0,0,             1,32'hFFFF_FFFC, 0,0,0,0));
        apply(mk(0,0,0,1,1,14,0,0,            1,32'h0000_0000, 0,0,0,0));
        apply(mk(0,0,0,0,1,15,0,0,            1,32'h0000_0004, 1,32'hFFFF_FFFC,14,0));
        apply(mk(0,0,0,0,0,0,0,0,             1,32'h0000_0004, 1,32'h0000_0000,15,0));
        apply(mk(0,0,0,0,0,0,0,0,             1,32'h0000_0004, 0,0,0,0));

        // Flush while a stalled entry is buffered: queue cleared, head not popped into the new path.
        apply(mk(0,0,0,1,0,0,0,0,         1,32'h0000_0004, 0,0,0,0));
        apply(mk(0,0,0,0,1,16,0,1,        1,32'h0000_0008, 0,0,0,0));
        apply(mk(1,32'h3000,0,0,0,0,0,1,  0,32'h0000_0008, 1,32'h0000_0004,16,0));
        apply(mk(0,0,0,0,0,0,0,0,         1,32'h0000_3000, 0,0,0,0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue_ctrl.md
Name: fetch_queue_ctrl

Overview:
- Sequences instruction fetch for the front end: issues word-aligned fetch requests to the I-side memory port and tracks outstanding requests with credits.
- Buffers returned words in a small FIFO and presents them, one entry per cycle, to the align stage as {valid, pc, data0, data1, except}.
- Handles pipeline flush/redirect by discarding in-flight responses and restarting at the redirect PC.
- Sits between the I-cache/memory port and the align stage.

Parameters:
- DEPTH, 4, FIFO entries and maximum in-flight requests plus buffered entries; power of two, at least 2.
- RESET_PC, 32'h8000_0000, first fetch address after reset; 4-byte aligned.
- EXCEPT_W, 4, exception code width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_flush  in  1  redirect pulse from back end.
- i_redirect_pc  in  32  new fetch PC; valid with i_flush; bits [1:0] must be 0.
- i_halt  in  1  stop issuing new requests; buffered entries still drain.
- o_req_valid  out  1  fetch request.
- o_req_pc  out  32  request address, 4-byte aligned.
- i_req_ready  in  1  memory accepts the request this cycle.
- i_resp_valid  in  1  response word; responses return in order.
- i_resp_data  in  32  {data1, data0}.
- i_resp_except  in  EXCEPT_W  exception code for the word.
- i_stall  in  1  align stage not consuming (align's o_stall).
- o_data_valid  out  1  head entry valid.
- o_data_pc  out  32  head PC.
- o_data_data0  out  16  low halfword.
- o_data_data1  out  16  high halfword.
- o_data_except  out  EXCEPT_W  head exception code.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE; fetch_pc=RESET_PC.
  - FIFO empty; outstanding=0; drop_cnt=0.
  - All outputs 0, except o_req_pc, which equals fetch_pc (RESET_PC).
- States:
  - IDLE → FETCH on the first cycle after reset release.
  - FETCH → HALT when i_halt=1.
  - HALT → FETCH when i_halt=0.
  - i_flush in any state keeps the current state apart from the redirect actions.
- Request issue: o_req_valid = (state==FETCH) & ~i_flush & (outstanding + count < DEPTH).
- Request acceptance (o_req_valid & i_req_ready): fetch_pc += 4, wrapping modulo 2^32; outstanding += 1.
- Response, no discard pending (drop_cnt==0): push {fetch PC of that request, data, except}; outstanding -= 1. The PC comes from a resp_pc register that advances by 4 per accepted response.
- Response with drop_cnt>0: discard the word; drop_cnt -= 1; outstanding -= 1.
- Pop when o_data_valid & ~i_stall. Head registers are driven from FIFO storage. FIFO empty gives o_data_valid=0 and zero data fields.
- Latency: a response is visible at o_data the cycle after i_resp_valid.
- Simultaneous push and pop: allowed at full and at empty; count unchanged (at empty, the pop applies only to a prior entry).
- Overflow is impossible by the credit rule. A response arriving with outstanding==0 is a protocol error; it is ignored.
- Flush actions, in the i_flush cycle:
  - FIFO cleared, including any same-cycle push; pop suppressed.
  - fetch_pc and resp_pc set to i_redirect_pc.
  - drop_cnt set to outstanding_next, i.e. all requests still in flight after this cycle's response is consumed. A response in the flush cycle is dropped, not pushed.
- Flush while drop_cnt>0: drop_cnt is reloaded with the same rule; no response is double-counted.
- Flush during HALT: PCs and queue are updated; no requests issue until i_halt=0.
- New requests may issue from the cycle after flush, even while drop_cnt>0.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When the FIFO is empty, drop_cnt==0, i_resp_valid=1 and no flush, the response drives o_data combinationally in the same cycle.
  - If ~i_stall, it is consumed without entering the FIFO; otherwise it is pushed as normal.
  - Latency is 0 cycles.
- Undefined: always through the FIFO; latency 1 cycle; o_data purely registered.

Test Plan:
- Reset release, i_req_ready=1, memory returns words 1 cycle after request → o_req_pc sequence 8000_0000, 8000_0004, 8000_0008…; o_data_pc matches, one entry per cycle, no gaps.
- i_stall=1 held for 10 cycles, DEPTH=4 → o_req_valid drops once outstanding+count=4; o_data holds the same head entry; release → four entries in order, no loss or duplication.
- 3 requests outstanding, i_flush with i_redirect_pc=0000_1000 → next 3 responses discarded; first o_data_valid has pc=0000_1000; o_data_valid=0 in the cycle after flush.
- i_flush coincident with i_resp_valid and 2 outstanding → that response dropped; drop_cnt=1; exactly one further response discarded.
- i_halt=1 mid-stream → no new requests; queue drains to empty; i_halt=0 → fetch resumes at the next sequential PC.
- Response with i_resp_except=4'h1 → o_data_except=1 on the matching pc; fetch_pc wrap FFFF_FFFC → 0000_0000.
